// File: rtl/axi_burst_normalizer.sv
// Splits AXI WRAP/FIXED bursts into INCR sub-bursts for the downstream bridge,
// regenerates W.last per sub-burst and merges the sub-burst responses on R/B.
module axi_burst_normalizer #(
    parameter int DataWidth = 64,
    parameter int AddrWidth = 56,
    parameter int IdWidth   = 1
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   host_aw_valid,
    output logic                   host_aw_ready,
    input  logic [IdWidth-1:0]     host_aw_id,
    input  logic [AddrWidth-1:0]   host_aw_addr,
    input  logic [7:0]             host_aw_len,
    input  logic [2:0]             host_aw_size,
    input  logic [1:0]             host_aw_burst,
    input  logic [3:0]             host_aw_cache,
    input  logic [2:0]             host_aw_prot,
    input  logic                   host_w_valid,
    output logic                   host_w_ready,
    input  logic [DataWidth-1:0]   host_w_data,
    input  logic [DataWidth/8-1:0] host_w_strb,
    input  logic                   host_w_last,
    output logic                   host_b_valid,
    input  logic                   host_b_ready,
    output logic [IdWidth-1:0]     host_b_id,
    output logic [1:0]             host_b_resp,
    input  logic                   host_ar_valid,
    output logic                   host_ar_ready,
    input  logic [IdWidth-1:0]     host_ar_id,
    input  logic [AddrWidth-1:0]   host_ar_addr,
    input  logic [7:0]             host_ar_len,
    input  logic [2:0]             host_ar_size,
    input  logic [1:0]             host_ar_burst,
    input  logic [3:0]             host_ar_cache,
    input  logic [2:0]             host_ar_prot,
    output logic                   host_r_valid,
    input  logic                   host_r_ready,
    output logic [IdWidth-1:0]     host_r_id,
    output logic [DataWidth-1:0]   host_r_data,
    output logic [1:0]             host_r_resp,
    output logic                   host_r_last,
    output logic                   device_aw_valid,
    input  logic                   device_aw_ready,
    output logic [IdWidth-1:0]     device_aw_id,
    output logic [AddrWidth-1:0]   device_aw_addr,
    output logic [7:0]             device_aw_len,
    output logic [2:0]             device_aw_size,
    output logic [1:0]             device_aw_burst,
    output logic [3:0]             device_aw_cache,
    output logic [2:0]             device_aw_prot,
    output logic                   device_w_valid,
    input  logic                   device_w_ready,
    output logic [DataWidth-1:0]   device_w_data,
    output logic [DataWidth/8-1:0] device_w_strb,
    output logic                   device_w_last,
    input  logic                   device_b_valid,
    output logic                   device_b_ready,
    input  logic [IdWidth-1:0]     device_b_id,
    input  logic [1:0]             device_b_resp,
    output logic                   device_ar_valid,
    input  logic                   device_ar_ready,
    output logic [IdWidth-1:0]     device_ar_id,
    output logic [AddrWidth-1:0]   device_ar_addr,
    output logic [7:0]             device_ar_len,
    output logic [2:0]             device_ar_size,
    output logic [1:0]             device_ar_burst,
    output logic [3:0]             device_ar_cache,
    output logic [2:0]             device_ar_prot,
    input  logic                   device_r_valid,
    output logic                   device_r_ready,
    input  logic [IdWidth-1:0]     device_r_id,
    input  logic [DataWidth-1:0]   device_r_data,
    input  logic [1:0]             device_r_resp,
    input  logic                   device_r_last
);

    typedef struct packed {
        logic [AddrWidth-1:0] addr0;
        logic [7:0]           len0;
        logic [AddrWidth-1:0] addr1;
        logic [7:0]           len1;
        logic [8:0]           count;
        logic                 fixed;
        logic                 split;
    } plan_t;

    // A WRAP whose start is aligned to the wrap boundary is already a plain INCR.
    function automatic plan_t plan_burst(input logic [AddrWidth-1:0] addr, input logic [7:0] len,
                                         input logic [2:0] size, input logic [1:0] burst);
        plan_t      p;
        logic [11:0] total, mask, off_bytes;
        logic [7:0]  off_beats;
        logic        wrap_ok;
        total     = (12'(len) + 12'd1) << size;
        mask      = total - 12'd1;
        off_bytes = addr[11:0] & mask;
        off_beats = 8'(off_bytes >> size);
        wrap_ok   = (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
        p.addr0 = addr;
        p.len0  = len;
        p.addr1 = addr;
        p.len1  = len;
        p.count = 9'd1;
        p.fixed = 1'b0;
        p.split = 1'b0;
        if (burst == 2'b00) begin
            p.len0  = 8'd0;
            p.len1  = 8'd0;
            p.count = 9'(len) + 9'd1;
            p.fixed = 1'b1;
        end else if (burst == 2'b10 && wrap_ok && off_beats != 8'd0) begin
            p.len0  = len - off_beats;
            p.addr1 = addr & ~AddrWidth'(mask);
            p.len1  = off_beats - 8'd1;
            p.count = 9'd2;
            p.split = 1'b1;
        end
        return p;
    endfunction

    function automatic logic [1:0] resp_max(input logic [1:0] a, input logic [1:0] b);
        return (a > b) ? a : b;
    endfunction

    typedef enum logic {ArIdle, ArIssue} ar_state_e;
    typedef enum logic {AwIdle, AwIssue} aw_state_e;

    ar_state_e ar_state_q, ar_state_d;
    aw_state_e aw_state_q, aw_state_d;
    plan_t     ar_plan, aw_plan;

    logic [AddrWidth-1:0] ar_cur_addr_q, ar_nxt_addr_q, aw_cur_addr_q, aw_nxt_addr_q;
    logic [7:0]           ar_cur_len_q, ar_nxt_len_q, aw_cur_len_q, aw_nxt_len_q;
    logic [8:0]           ar_iss_left_q, aw_iss_left_q, r_sub_left_q, b_sub_left_q;
    logic [IdWidth-1:0]   ar_id_q, aw_id_q;
    logic [2:0]           ar_size_q, aw_size_q, ar_prot_q, aw_prot_q;
    logic [3:0]           ar_cache_q, aw_cache_q;
    logic                 w_busy_q, w_fixed_q, w_split_q;
    logic [7:0]           w_beat_q, w_last_beat_q, w_split_beat_q;
    logic [1:0]           merged_resp_q;
    logic                 r_busy, b_busy, b_final;
    logic                 ar_accept, aw_accept, r_sub_done, w_hs, b_hs;
    logic                 unused_ar_flags, unused_w_last;

    assign ar_plan         = plan_burst(host_ar_addr, host_ar_len, host_ar_size, host_ar_burst);
    assign aw_plan         = plan_burst(host_aw_addr, host_aw_len, host_aw_size, host_aw_burst);
    assign unused_ar_flags = ar_plan.fixed ^ ar_plan.split;
    assign unused_w_last   = host_w_last;

    assign r_busy     = (r_sub_left_q != 9'd0);
    assign b_busy     = (b_sub_left_q != 9'd0);
    assign b_final    = (b_sub_left_q == 9'd1);
    assign ar_accept  = host_ar_valid && host_ar_ready;
    assign aw_accept  = host_aw_valid && host_aw_ready;
    assign r_sub_done = device_r_valid && device_r_ready && device_r_last && r_busy;
    assign w_hs       = device_w_valid && device_w_ready;
    assign b_hs       = device_b_valid && device_b_ready;

    always_comb begin
        ar_state_d      = ar_state_q;
        host_ar_ready   = 1'b0;
        device_ar_valid = 1'b0;
        case (ar_state_q)
            ArIdle: begin
                host_ar_ready = rst_ni && !r_busy;
                if (host_ar_valid && host_ar_ready) ar_state_d = ArIssue;
            end
            ArIssue: begin
                device_ar_valid = 1'b1;
                if (device_ar_ready && ar_iss_left_q == 9'd1) ar_state_d = ArIdle;
            end
            default: ar_state_d = ArIdle;
        endcase
    end

    always_comb begin
        aw_state_d      = aw_state_q;
        host_aw_ready   = 1'b0;
        device_aw_valid = 1'b0;
        case (aw_state_q)
            AwIdle: begin
                host_aw_ready = rst_ni && !w_busy_q && !b_busy;
                if (host_aw_valid && host_aw_ready) aw_state_d = AwIssue;
            end
            AwIssue: begin
                device_aw_valid = 1'b1;
                if (device_aw_ready && aw_iss_left_q == 9'd1) aw_state_d = AwIdle;
            end
            default: aw_state_d = AwIdle;
        endcase
    end

    assign device_ar_id    = ar_id_q;
    assign device_ar_addr  = ar_cur_addr_q;
    assign device_ar_len   = ar_cur_len_q;
    assign device_ar_size  = ar_size_q;
    assign device_ar_burst = 2'b01;
    assign device_ar_cache = ar_cache_q;
    assign device_ar_prot  = ar_prot_q;
    assign device_aw_id    = aw_id_q;
    assign device_aw_addr  = aw_cur_addr_q;
    assign device_aw_len   = aw_cur_len_q;
    assign device_aw_size  = aw_size_q;
    assign device_aw_burst = 2'b01;
    assign device_aw_cache = aw_cache_q;
    assign device_aw_prot  = aw_prot_q;

    assign host_r_valid   = device_r_valid;
    assign device_r_ready = host_r_ready;
    assign host_r_id      = device_r_id;
    assign host_r_data    = device_r_data;
    assign host_r_resp    = device_r_resp;
    assign host_r_last    = device_r_last && (r_sub_left_q == 9'd1);

    // host W.last is ignored: downstream last is rebuilt from the sub-burst plan.
    assign host_w_ready   = device_w_ready && w_busy_q;
    assign device_w_valid = host_w_valid && w_busy_q;
    assign device_w_data  = host_w_data;
    assign device_w_strb  = host_w_strb;
    assign device_w_last  = w_fixed_q || (w_beat_q == w_last_beat_q) ||
                            (w_split_q && w_beat_q == w_split_beat_q);

    // Only the final sub-burst response reaches the host; earlier ones are absorbed.
    assign device_b_ready = b_busy && (b_final ? host_b_ready : 1'b1);
    assign host_b_valid   = device_b_valid && b_final;
    assign host_b_id      = device_b_id;
    assign host_b_resp    = resp_max(merged_resp_q, device_b_resp);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ar_state_q    <= ArIdle;
            ar_cur_addr_q <= '0;
            ar_nxt_addr_q <= '0;
            ar_cur_len_q  <= '0;
            ar_nxt_len_q  <= '0;
            ar_iss_left_q <= '0;
            r_sub_left_q  <= '0;
            ar_id_q       <= '0;
            ar_size_q     <= '0;
            ar_cache_q    <= '0;
            ar_prot_q     <= '0;
        end else begin
            ar_state_q <= ar_state_d;
            if (ar_accept) begin
                ar_cur_addr_q <= ar_plan.addr0;
                ar_cur_len_q  <= ar_plan.len0;
                ar_nxt_addr_q <= ar_plan.addr1;
                ar_nxt_len_q  <= ar_plan.len1;
                ar_iss_left_q <= ar_plan.count;
                r_sub_left_q  <= ar_plan.count;
                ar_id_q       <= host_ar_id;
                ar_size_q     <= host_ar_size;
                ar_cache_q    <= host_ar_cache;
                ar_prot_q     <= host_ar_prot;
            end else begin
                if (device_ar_valid && device_ar_ready) begin
                    ar_cur_addr_q <= ar_nxt_addr_q;
                    ar_cur_len_q  <= ar_nxt_len_q;
                    ar_iss_left_q <= ar_iss_left_q - 9'd1;
                end
                if (r_sub_done) r_sub_left_q <= r_sub_left_q - 9'd1;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            aw_state_q     <= AwIdle;
            aw_cur_addr_q  <= '0;
            aw_nxt_addr_q  <= '0;
            aw_cur_len_q   <= '0;
            aw_nxt_len_q   <= '0;
            aw_iss_left_q  <= '0;
            b_sub_left_q   <= '0;
            aw_id_q        <= '0;
            aw_size_q      <= '0;
            aw_cache_q     <= '0;
            aw_prot_q      <= '0;
            w_busy_q       <= 1'b0;
            w_fixed_q      <= 1'b0;
            w_split_q      <= 1'b0;
            w_beat_q       <= '0;
            w_last_beat_q  <= '0;
            w_split_beat_q <= '0;
            merged_resp_q  <= '0;
        end else begin
            aw_state_q <= aw_state_d;
            if (aw_accept) begin
                aw_cur_addr_q  <= aw_plan.addr0;
                aw_cur_len_q   <= aw_plan.len0;
                aw_nxt_addr_q  <= aw_plan.addr1;
                aw_nxt_len_q   <= aw_plan.len1;
                aw_iss_left_q  <= aw_plan.count;
                b_sub_left_q   <= aw_plan.count;
                aw_id_q        <= host_aw_id;
                aw_size_q      <= host_aw_size;
                aw_cache_q     <= host_aw_cache;
                aw_prot_q      <= host_aw_prot;
                w_busy_q       <= 1'b1;
                w_fixed_q      <= aw_plan.fixed;
                w_split_q      <= aw_plan.split;
                w_beat_q       <= '0;
                w_last_beat_q  <= host_aw_len;
                w_split_beat_q <= aw_plan.len0;
            end else begin
                if (device_aw_valid && device_aw_ready) begin
                    aw_cur_addr_q <= aw_nxt_addr_q;
                    aw_cur_len_q  <= aw_nxt_len_q;
                    aw_iss_left_q <= aw_iss_left_q - 9'd1;
                end
                if (w_hs) begin
                    if (w_beat_q == w_last_beat_q) begin
                        w_busy_q <= 1'b0;
                        w_beat_q <= '0;
                    end else begin
                        w_beat_q <= w_beat_q + 8'd1;
                    end
                end
                if (b_hs) begin
                    b_sub_left_q  <= b_sub_left_q - 9'd1;
                    merged_resp_q <= b_final ? 2'b00 : resp_max(merged_resp_q, device_b_resp);
                end
            end
        end
    end

endmodule

// File: tb/tb_axi_burst_normalizer.sv
// Directed bench for axi_burst_normalizer: vector table of bursts with hand-computed
// sub-burst splits and responses, plus reset / W-early / B-backpressure sequences.
module tb_axi_burst_normalizer;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    logic        host_aw_valid = 0, host_aw_ready;
    logic [0:0]  host_aw_id = 0;
    logic [55:0] host_aw_addr = 0;
    logic [7:0]  host_aw_len = 0;
    logic [2:0]  host_aw_size = 0, host_aw_prot = 0;
    logic [1:0]  host_aw_burst = 0;
    logic [3:0]  host_aw_cache = 0;
    logic        host_w_valid = 0, host_w_ready, host_w_last = 0;
    logic [63:0] host_w_data = 0;
    logic [7:0]  host_w_strb = 8'hFF;
    logic        host_b_valid, host_b_ready = 0;
    logic [0:0]  host_b_id;
    logic [1:0]  host_b_resp;
    logic        host_ar_valid = 0, host_ar_ready;
    logic [0:0]  host_ar_id = 0;
    logic [55:0] host_ar_addr = 0;
    logic [7:0]  host_ar_len = 0;
    logic [2:0]  host_ar_size = 0, host_ar_prot = 0;
    logic [1:0]  host_ar_burst = 0;
    logic [3:0]  host_ar_cache = 0;
    logic        host_r_valid, host_r_ready = 0, host_r_last;
    logic [0:0]  host_r_id;
    logic [63:0] host_r_data;
    logic [1:0]  host_r_resp;
    logic        device_aw_valid, device_aw_ready = 0;
    logic [0:0]  device_aw_id;
    logic [55:0] device_aw_addr;
    logic [7:0]  device_aw_len;
    logic [2:0]  device_aw_size, device_aw_prot;
    logic [1:0]  device_aw_burst;
    logic [3:0]  device_aw_cache;
    logic        device_w_valid, device_w_ready = 0, device_w_last;
    logic [63:0] device_w_data;
    logic [7:0]  device_w_strb;
    logic        device_b_valid = 0, device_b_ready;
    logic [0:0]  device_b_id = 0;
    logic [1:0]  device_b_resp = 0;
    logic        device_ar_valid, device_ar_ready = 0;
    logic [0:0]  device_ar_id;
    logic [55:0] device_ar_addr;
    logic [7:0]  device_ar_len;
    logic [2:0]  device_ar_size, device_ar_prot;
    logic [1:0]  device_ar_burst;
    logic [3:0]  device_ar_cache;
    logic        device_r_valid = 0, device_r_ready, device_r_last = 0;
    logic [0:0]  device_r_id = 0;
    logic [63:0] device_r_data = 0;
    logic [1:0]  device_r_resp = 0;

    axi_burst_normalizer dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .host_aw_valid(host_aw_valid), .host_aw_ready(host_aw_ready), .host_aw_id(host_aw_id),
        .host_aw_addr(host_aw_addr), .host_aw_len(host_aw_len), .host_aw_size(host_aw_size),
        .host_aw_burst(host_aw_burst), .host_aw_cache(host_aw_cache), .host_aw_prot(host_aw_prot),
        .host_w_valid(host_w_valid), .host_w_ready(host_w_ready), .host_w_data(host_w_data),
        .host_w_strb(host_w_strb), .host_w_last(host_w_last),
        .host_b_valid(host_b_valid), .host_b_ready(host_b_ready), .host_b_id(host_b_id),
        .host_b_resp(host_b_resp),
        .host_ar_valid(host_ar_valid), .host_ar_ready(host_ar_ready), .host_ar_id(host_ar_id),
        .host_ar_addr(host_ar_addr), .host_ar_len(host_ar_len), .host_ar_size(host_ar_size),
        .host_ar_burst(host_ar_burst), .host_ar_cache(host_ar_cache), .host_ar_prot(host_ar_prot),
        .host_r_valid(host_r_valid), .host_r_ready(host_r_ready), .host_r_id(host_r_id),
        .host_r_data(host_r_data), .host_r_resp(host_r_resp), .host_r_last(host_r_last),
        .device_aw_valid(device_aw_valid), .device_aw_ready(device_aw_ready),
        .device_aw_id(device_aw_id), .device_aw_addr(device_aw_addr), .device_aw_len(device_aw_len),
        .device_aw_size(device_aw_size), .device_aw_burst(device_aw_burst),
        .device_aw_cache(device_aw_cache), .device_aw_prot(device_aw_prot),
        .device_w_valid(device_w_valid), .device_w_ready(device_w_ready),
        .device_w_data(device_w_data), .device_w_strb(device_w_strb), .device_w_last(device_w_last),
        .device_b_valid(device_b_valid), .device_b_ready(device_b_ready),
        .device_b_id(device_b_id), .device_b_resp(device_b_resp),
        .device_ar_valid(device_ar_valid), .device_ar_ready(device_ar_ready),
        .device_ar_id(device_ar_id), .device_ar_addr(device_ar_addr), .device_ar_len(device_ar_len),
        .device_ar_size(device_ar_size), .device_ar_burst(device_ar_burst),
        .device_ar_cache(device_ar_cache), .device_ar_prot(device_ar_prot),
        .device_r_valid(device_r_valid), .device_r_ready(device_r_ready),
        .device_r_id(device_r_id), .device_r_data(device_r_data), .device_r_resp(device_r_resp),
        .device_r_last(device_r_last)
    );

    typedef struct {
        logic [1:0]      burst;
        logic [55:0]     addr;
        logic [7:0]      len;
        logic [2:0]      size;
        int              nsub;
        logic [55:0]     a0;
        logic [7:0]      l0;
        logic [55:0]     a1;
        logic [7:0]      l1;
        logic [3:0][1:0] resps;
        logic [1:0]      eresp;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t rv[7];
    vec_t wv[4];
    logic [55:0] cap_a[16];
    logic [7:0]  cap_l[16];
    logic [1:0]  cap_b[16];
    logic [2:0]  cap_s[16];

    function automatic vec_t mk(input logic [1:0] burst, input logic [55:0] addr,
                                input logic [7:0] len, input logic [2:0] size, input int nsub,
                                input logic [55:0] a0, input logic [7:0] l0,
                                input logic [55:0] a1, input logic [7:0] l1,
                                input logic [3:0][1:0] resps, input logic [1:0] eresp);
        vec_t v;
        v.burst = burst; v.addr = addr; v.len = len; v.size = size; v.nsub = nsub;
        v.a0 = a0; v.l0 = l0; v.a1 = a1; v.l1 = l1; v.resps = resps; v.eresp = eresp;
        return v;
    endfunction

    // Beat b closes a downstream sub-burst when it hits a cumulative sub-burst end.
    function automatic logic is_sub_last(input vec_t v, input int b);
        int cum = 0;
        for (int k = 0; k < v.nsub; k++) begin
            cum += ((k == 0) ? int'(v.l0) : int'(v.l1)) + 1;
            if (b == cum - 1) return 1'b1;
        end
        return 1'b0;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_accept(input bit is_w);
        int n = 0;
        @(negedge clk);
        while (!(is_w ? host_aw_ready : host_ar_ready) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(is_w ? "aw_accept" : "ar_accept", is_w ? host_aw_ready : host_ar_ready, 1);
        @(posedge clk); #1;
        host_aw_valid = 0;
        host_ar_valid = 0;
    endtask

    task automatic capture(input bit is_w, output int got);
        got = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (is_w ? device_aw_valid : device_ar_valid) begin
                if (got < 16) begin
                    cap_a[got] = is_w ? device_aw_addr : device_ar_addr;
                    cap_l[got] = is_w ? device_aw_len : device_ar_len;
                    cap_b[got] = is_w ? device_aw_burst : device_ar_burst;
                    cap_s[got] = is_w ? device_aw_size : device_ar_size;
                end
                got++;
            end else if (got > 0) begin
                break;
            end
        end
        @(posedge clk); #1;
    endtask

    task automatic check_subs(input vec_t v, input int got, input bit is_w);
        chk(is_w ? "aw_nsub" : "ar_nsub", got, v.nsub);
        for (int k = 0; k < got && k < v.nsub && k < 16; k++) begin
            chk(is_w ? "aw_addr" : "ar_addr", cap_a[k], (k == 0) ? v.a0 : v.a1);
            chk(is_w ? "aw_len" : "ar_len", cap_l[k], (k == 0) ? v.l0 : v.l1);
            chk(is_w ? "aw_burst" : "ar_burst", cap_b[k], 2'b01);
            chk(is_w ? "aw_size" : "ar_size", cap_s[k], v.size);
        end
    endtask

    task automatic run_ar(input vec_t v, input int idx);
        int got;
        host_ar_valid = 1; host_ar_addr = v.addr; host_ar_len = v.len;
        host_ar_size = v.size; host_ar_burst = v.burst; device_ar_ready = 1;
        wait_accept(1'b0);
        capture(1'b0, got);
        check_subs(v, got, 1'b0);
        host_r_ready = 1;
        for (int b = 0; b <= int'(v.len); b++) begin
            device_r_valid = 1;
            device_r_data  = 64'hA500_0000_0000_0000 | 64'(b);
            device_r_last  = is_sub_last(v, b);
            @(negedge clk);
            chk("r_last", host_r_last, (b == int'(v.len)) ? 1 : 0);
            if (b == 0) chk("r_data", host_r_data, 64'hA500_0000_0000_0000);
            @(posedge clk); #1;
        end
        device_r_valid = 0; device_r_last = 0; host_r_ready = 0;
        @(negedge clk);
        chk("r_busy_clear", host_ar_ready, 1);
        @(posedge clk); #1;
        $display("AR vec %0d: addr=0x%0h len=%0d burst=%0d -> %0d sub-bursts", idx, v.addr, v.len,
                 v.burst, got);
    endtask

    task automatic run_aw(input vec_t v, input int idx, input int w_early, input int b_hold);
        int got;
        if (w_early > 0) begin
            host_w_valid = 1; device_w_ready = 1;
            for (int c = 0; c < w_early; c++) begin
                @(negedge clk);
                chk("w_early_ready", host_w_ready, 0);
                chk("w_early_valid", device_w_valid, 0);
                @(posedge clk); #1;
            end
        end
        device_w_ready = 0;
        host_aw_valid = 1; host_aw_addr = v.addr; host_aw_len = v.len;
        host_aw_size = v.size; host_aw_burst = v.burst; device_aw_ready = 1;
        wait_accept(1'b1);
        capture(1'b1, got);
        check_subs(v, got, 1'b1);
        for (int b = 0; b <= int'(v.len); b++) begin
            host_w_valid = 1; device_w_ready = 1;
            host_w_last  = (b == 0);
            host_w_data  = 64'h5A00 | 64'(b);
            @(negedge clk);
            chk("w_ready", host_w_ready, 1);
            chk("w_last", device_w_last, is_sub_last(v, b));
            if (b == 0) chk("w_data", device_w_data, 64'h5A00);
            @(posedge clk); #1;
        end
        host_w_last = 0;
        @(negedge clk);
        chk("w_busy_clear", host_w_ready, 0);
        @(posedge clk); #1;
        host_w_valid = 0; device_w_ready = 0;
        for (int k = 0; k < v.nsub; k++) begin
            device_b_valid = 1;
            device_b_resp  = v.resps[k];
            if (k == v.nsub - 1) begin
                host_b_ready = (b_hold == 0);
                for (int c = 0; c < b_hold; c++) begin
                    @(negedge clk);
                    chk("b_hold_valid", host_b_valid, 1);
                    chk("b_hold_resp", host_b_resp, v.eresp);
                    chk("b_hold_dready", device_b_ready, 0);
                    @(posedge clk); #1;
                end
            end
            host_b_ready = 1;
            @(negedge clk);
            chk("b_valid", host_b_valid, (k == v.nsub - 1) ? 1 : 0);
            chk("b_dready", device_b_ready, 1);
            if (k == v.nsub - 1) chk("b_resp", host_b_resp, v.eresp);
            @(posedge clk); #1;
        end
        device_b_valid = 0; host_b_ready = 0;
        @(negedge clk);
        chk("b_busy_clear", host_aw_ready, 1);
        @(posedge clk); #1;
        $display("AW vec %0d: addr=0x%0h len=%0d burst=%0d -> %0d sub-bursts, resp=%0d", idx,
                 v.addr, v.len, v.burst, got, v.eresp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    initial begin
        rv[0] = mk(2'd1, 56'h100, 8'd3, 3'd3, 1, 56'h100, 8'd3, 56'h100, 8'd3, 8'h00, 2'd0);
        rv[1] = mk(2'd2, 56'h118, 8'd3, 3'd3, 2, 56'h118, 8'd0, 56'h100, 8'd2, 8'h00, 2'd0);
        rv[2] = mk(2'd2, 56'h100, 8'd7, 3'd3, 1, 56'h100, 8'd7, 56'h100, 8'd7, 8'h00, 2'd0);
        rv[3] = mk(2'd0, 56'h40, 8'd2, 3'd2, 3, 56'h40, 8'd0, 56'h40, 8'd0, 8'h00, 2'd0);
        rv[4] = mk(2'd3, 56'h200, 8'd1, 3'd3, 1, 56'h200, 8'd1, 56'h200, 8'd1, 8'h00, 2'd0);
        rv[5] = mk(2'd2, 56'h208, 8'd2, 3'd3, 1, 56'h208, 8'd2, 56'h208, 8'd2, 8'h00, 2'd0);
        rv[6] = mk(2'd2, 56'h3C, 8'd15, 3'd2, 2, 56'h3C, 8'd0, 56'h0, 8'd14, 8'h00, 2'd0);
        wv[0] = mk(2'd0, 56'h40, 8'd2, 3'd2, 3, 56'h40, 8'd0, 56'h40, 8'd0, 8'b00_00_00_01, 2'd1);
        wv[1] = mk(2'd2, 56'h30, 8'd3, 3'd3, 2, 56'h30, 8'd1, 56'h20, 8'd1, 8'b00_00_10_00, 2'd2);
        wv[2] = mk(2'd2, 56'h34, 8'd1, 3'd2, 2, 56'h34, 8'd0, 56'h30, 8'd0, 8'b00_00_00_10, 2'd2);
        wv[3] = mk(2'd1, 56'h1000, 8'd0, 3'd3, 1, 56'h1000, 8'd0, 56'h1000, 8'd0, 8'b00_00_00_11, 2'd3);

        #2;
        chk("rst_ar_ready", host_ar_ready, 0);
        chk("rst_aw_ready", host_aw_ready, 0);
        chk("rst_dar_valid", device_ar_valid, 0);
        chk("rst_daw_valid", device_aw_valid, 0);
        chk("rst_dw_valid", device_w_valid, 0);
        chk("rst_b_valid", host_b_valid, 0);
        repeat (2) @(posedge clk);
        #1 rst_ni = 1;

        for (int i = 0; i < 7; i++) run_ar(rv[i], i);
        for (int i = 0; i < 3; i++) run_aw(wv[i], i, 0, 0);
        run_aw(wv[3], 3, 3, 5);

        // Reset in the middle of a split read: residual sub-burst count must vanish.
        begin
            int got;
            host_ar_valid = 1; host_ar_addr = rv[1].addr; host_ar_len = rv[1].len;
            host_ar_size = rv[1].size; host_ar_burst = rv[1].burst; device_ar_ready = 1;
            wait_accept(1'b0);
            capture(1'b0, got);
            device_r_valid = 1; device_r_last = 1; host_r_ready = 1;
            @(negedge clk);
            chk("pre_rst_r_last0", host_r_last, 0);
            @(posedge clk); #1;
            @(negedge clk);
            chk("pre_rst_r_last1", host_r_last, 1);
            #1 rst_ni = 0;
            #1;
            chk("mid_rst_r_last", host_r_last, 0);
            chk("mid_rst_dar_valid", device_ar_valid, 0);
            chk("mid_rst_daw_valid", device_aw_valid, 0);
            chk("mid_rst_b_valid", host_b_valid, 0);
            chk("mid_rst_ar_ready", host_ar_ready, 0);
            @(posedge clk); #1;
            rst_ni = 1;
            device_r_valid = 0; device_r_last = 0; host_r_ready = 0;
            @(negedge clk);
            chk("post_rst_ar_ready", host_ar_ready, 1);
            chk("post_rst_dar_valid", device_ar_valid, 0);
            @(posedge clk); #1;
            $display("RESET mid-read sequence done");
        end
        run_ar(mk(2'd1, 56'h500, 8'd1, 3'd3, 1, 56'h500, 8'd1, 56'h500, 8'd1, 8'h00, 2'd0), 7);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
